// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring unsigned divider.
// The divide-by-zero quotient constant is sized for the widest supported operand.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MAX_WIDTH = 64;

    // All-ones quotient reported on divide-by-zero; sliced to WIDTH by the user.
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage : div_pkg

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// then trial-subtract the divisor with one extra bit so the sign shows borrow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted_rem = {rem, quo[WIDTH-1]};
        trial       = shifted_rem - {1'b0, divisor};
        // trial[WIDTH] set means the subtract borrowed: restore the shifted remainder.
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_rem[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule : div_step

// File: rtl/unsigned_sequential_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, with
// divide-by-zero short-cut and a one-cycle done pulse after the DONE state.
module unsigned_sequential_divider
    import div_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_by_zero
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] quo, quo_next;
    logic [WIDTH-1:0] rem, rem_next;
    logic [WIDTH-1:0] dvsr, dvsr_next;
    logic             busy_next;
    logic             done_next;
    logic             dbz, dbz_next;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             accept;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        quo_next   = quo;
        rem_next   = rem;
        dvsr_next  = dvsr;
        dbz_next   = dbz;
        done_next  = 1'b0;
        accept     = start && (state != RUN);

        case (state)
            IDLE: state_next = IDLE;
            RUN: begin
                quo_next = step_quo;
                rem_next = step_rem;
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A new request overrides the IDLE/DONE transition; done above still pulses.
        if (accept) begin
            dvsr_next = divisor_in;
            if (divisor_in == '0) begin
                quo_next   = DIV_ZERO_QUOTIENT[WIDTH-1:0];
                rem_next   = dividend_in;
                cnt_next   = '0;
                dbz_next   = 1'b1;
                state_next = DONE;
            end else begin
                quo_next   = dividend_in;
                rem_next   = '0;
                cnt_next   = CNT_W'(WIDTH);
                dbz_next   = 1'b0;
                state_next = RUN;
            end
        end

        busy_next = (state_next == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            quo   <= quo_next;
            rem   <= rem_next;
            dvsr  <= dvsr_next;
            busy  <= busy_next;
            done  <= done_next;
            dbz   <= dbz_next;
        end
    end

    assign quotient_out  = quo;
    assign remainder_out = rem;
    assign div_by_zero   = dbz;

endmodule : unsigned_sequential_divider

// File: tb/tb_unsigned_sequential_divider.sv
// Self-checking bench for unsigned_sequential_divider: directed corner cases plus
// randomized operands against a plain-arithmetic reference model.
module tb_unsigned_sequential_divider;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend_in;
    logic [WIDTH-1:0] divisor_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient_out;
    logic [WIDTH-1:0] remainder_out;
    logic             div_by_zero;

    int n_vectors;
    int n_miscompares;

    unsigned_sequential_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .busy          (busy),
        .done          (done),
        .quotient_out  (quotient_out),
        .remainder_out (remainder_out),
        .div_by_zero   (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the arithmetic definition of unsigned division.
    function automatic void ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                                    output logic dz);
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endfunction

    // Present one start pulse; returns just after the accepting edge (edge 0).
    task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        start       = 1'b1;
        dividend_in = a;
        divisor_in  = b;
        @(posedge clk);
        #1;
        start       = 1'b0;
        dividend_in = $urandom;
        divisor_in  = $urandom;
    endtask

    // Step edges until done rises; optionally pulse start at cycle inject_at.
    task automatic wait_done(input int inject_at, input logic [WIDTH-1:0] ia,
                             input logic [WIDTH-1:0] ib, output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (cyc < 100) begin
            if (cyc == inject_at) begin
                start       = 1'b1;
                dividend_in = ia;
                divisor_in  = ib;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input int cyc, input int busy_cyc);
        logic [WIDTH-1:0] eq, er;
        logic             edz;
        ref_div(a, b, eq, er, edz);
        check($sformatf("%s latency %0d/%0d", tag, a, b), 64'(cyc),
              (b == 0) ? 64'(1) : 64'(WIDTH + 1));
        check($sformatf("%s busy_cycles %0d/%0d", tag, a, b), 64'(busy_cyc),
              (b == 0) ? 64'(0) : 64'(WIDTH));
        check($sformatf("%s quotient %0d/%0d", tag, a, b), 64'(quotient_out), 64'(eq));
        check($sformatf("%s remainder %0d/%0d", tag, a, b), 64'(remainder_out), 64'(er));
        check($sformatf("%s div_by_zero %0d/%0d", tag, a, b), 64'(div_by_zero), 64'(edz));
    endtask

    task automatic do_div(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int cyc, busy_cyc;
        launch(a, b);
        wait_done(-1, '0, '0, cyc, busy_cyc);
        check_result(tag, a, b, cyc, busy_cyc);
        @(posedge clk);
        #1;
        check($sformatf("%s done_one_cycle", tag), 64'(done), 64'(0));
    endtask

    initial begin
        int               cyc, busy_cyc;
        logic [WIDTH-1:0] a, b;

        n_vectors     = 0;
        n_miscompares = 0;
        rst           = 1'b0;
        start         = 1'b0;
        dividend_in   = '0;
        divisor_in    = '0;

        #12;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset quotient", 64'(quotient_out), 64'(0));
        check("reset remainder", 64'(remainder_out), 64'(0));
        check("reset div_by_zero", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        do_div("basic", 32'd100, 32'd7);
        do_div("max_by_one", 32'hFFFF_FFFF, 32'd1);
        do_div("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_div("div_zero", 32'd5, 32'd0);
        do_div("after_dz", 32'd77, 32'd11);
        do_div("zero_dividend", 32'd0, 32'd13);
        do_div("small_dividend", 32'd3, 32'd10);

        // Back-to-back: new request while the first result sits in DONE.
        launch(32'd3, 32'd10);
        repeat (WIDTH) @(posedge clk);
        #1;
        check("b2b first quotient", 64'(quotient_out), 64'(0));
        check("b2b first remainder", 64'(remainder_out), 64'(3));
        check("b2b first done_not_yet", 64'(done), 64'(0));
        start       = 1'b1;
        dividend_in = 32'h8000_0000;
        divisor_in  = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b done_pulse", 64'(done), 64'(1));
        check("b2b busy_after_accept", 64'(busy), 64'(1));
        wait_done(-1, '0, '0, cyc, busy_cyc);
        check_result("b2b second", 32'h8000_0000, 32'd3, cyc, busy_cyc);
        check("b2b quotient_const", 64'(quotient_out), 64'(32'h2AAA_AAAA));

        // Start while running is ignored.
        launch(32'd1000, 32'd9);
        wait_done(10, 32'd50, 32'd5, cyc, busy_cyc);
        check_result("ignore_start", 32'd1000, 32'd9, cyc, busy_cyc);

        // Asynchronous reset mid-operation abandons it with no done.
        launch(32'd1000, 32'd9);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midreset busy", 64'(busy), 64'(0));
        check("midreset done", 64'(done), 64'(0));
        check("midreset quotient", 64'(quotient_out), 64'(0));
        check("midreset remainder", 64'(remainder_out), 64'(0));
        check("midreset div_by_zero", 64'(div_by_zero), 64'(0));
        repeat (WIDTH + 4) @(posedge clk);
        #1;
        check("midreset no_done", 64'(done), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (WIDTH + 4) @(posedge clk);
        #1;
        check("postreset idle_done", 64'(done), 64'(0));
        check("postreset idle_busy", 64'(busy), 64'(0));
        do_div("after_reset", 32'd1000, 32'd9);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 16));
                2:       b = 32'd0;
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_div("random", a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule : tb_unsigned_sequential_divider

// File: doc/unsigned_sequential_divider.md
Name: unsigned_sequential_divider

Overview:
Iterative restoring unsigned divider. It is the inverse-direction companion to the team's shift-add unsigned multiplier datapath and lives in the same arithmetic-unit area.
It accepts dividend and divisor on a start pulse and produces one quotient bit per clock. It reports quotient, remainder and a divide-by-zero flag with a single-cycle done pulse.
The results are consumed by the same top-level controller that sequences the multiplier.

Parameters:
WIDTH, 32, operand, quotient and remainder width in bits (must be ≥ 2)
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only when not busy
dividend_in  input  WIDTH  unsigned dividend, sampled with an accepted start
divisor_in  input  WIDTH  unsigned divisor, sampled with an accepted start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse when results become valid
quotient_out  output  WIDTH  quotient; held stable until the next accepted start
remainder_out  output  WIDTH  remainder; held stable until the next accepted start
div_by_zero  output  1  set with done when divisor was 0; held with the results

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; busy=0, done=0, div_by_zero=0, quotient_out=0, remainder_out=0, counter=0, internal divisor=0. An operation in flight is abandoned with no done.
- States: IDLE, RUN, DONE.
- Start acceptance:
  - A start is accepted in IDLE or DONE.
  - A start in RUN is ignored; operands are not re-sampled.
- Accept edge, divisor_in != 0:
  - Latch Q=dividend_in, D=divisor_in, R=0, counter=WIDTH, clear div_by_zero.
  - Go to RUN.
- Accept edge, divisor_in == 0:
  - Q=all ones, R=dividend_in, div_by_zero=1.
  - Go to DONE. No RUN cycles.
- RUN, one iteration per clock:
  - {R,Q} shifted left 1.
  - trial = shifted R − D, computed at WIDTH+1 bits.
  - If trial ≥ 0: R=trial[WIDTH-1:0] and Q[0]=1. Otherwise R keeps the shifted value and Q[0]=0.
  - counter decrements. When counter reaches 1 on this edge, the next state is DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE unless start is high.
  - A start during DONE is accepted (DONE→RUN, or DONE→DONE for divide-by-zero) and done still pulses that cycle.
- Latency (start accepted at edge 0):
  - Normal case: busy is high from edge 0 through edge WIDTH; done is high after edge WIDTH+1 (33 for WIDTH=32).
  - Divide-by-zero: done is high after edge 1; busy never rises.
- Output registers: quotient_out and remainder_out are the Q and R registers. They may change during RUN and are valid only from done onward.
- Boundaries:
  - Dividend < divisor gives Q=0, R=dividend.
  - Divisor=1 gives Q=dividend, R=0.
  - Dividend=0 gives Q=0, R=0.
  - Max operands must not overflow, because the trial subtract carries one extra bit.

Decomposition:
- Shared package (div_pkg) holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the DIV_ZERO_QUOTIENT constant (all ones).
- One natural sub-module, div_step: a combinational single iteration. Inputs R, Q, D; outputs next R, next Q.
- The FSM, counter and registers stay in the top.

Test Plan:
- 100 / 7 → quotient_out=14, remainder_out=2, div_by_zero=0; done exactly 33 cycles after the start edge; busy high for 32 cycles.
- 0xFFFFFFFF / 1 → quotient_out=0xFFFFFFFF, remainder_out=0; also 0xFFFFFFFF / 0xFFFFFFFF → quotient_out=1, remainder_out=0.
- 5 / 0 → quotient_out=0xFFFFFFFF, remainder_out=5, div_by_zero=1; done 1 cycle after start; busy stays 0.
- 3 / 10 → quotient_out=0, remainder_out=3. Then start 0x80000000 / 3 during the DONE cycle → accepted; quotient_out=0x2AAAAAAA, remainder_out=2.
- Start 1000 / 9, then pulse start with 50 / 5 at cycle 10 → second request ignored; result quotient_out=111, remainder_out=1 at cycle 33.
- Start 1000 / 9, drive rst low at cycle 15 (between edges) → all outputs 0 immediately; no done; after release, 1000 / 9 completes normally.
